// File: rtl/dsp19x2_fir_seq_pkg.sv
// Shared types and constants for the DSP19X2 dual-lane FIR sequencer.
package dsp19x2_fir_seq_pkg;

  localparam int A_W      = 10;
  localparam int B_W      = 9;
  localparam int Z_W      = 19;
  localparam int SHIFT_W  = 5;
  localparam int MAX_TAPS = 8;
  localparam int WAIT_W   = 3;

  localparam logic [2:0] FB_ACCUM = 3'b000;
  localparam logic [2:0] FB_CLEAR = 3'b001;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_e;

  // Coefficient k of a packed table widened to the maximum tap count.
  function automatic logic [A_W-1:0] coeff_slice(input logic [MAX_TAPS*A_W-1:0] table_c,
                                                 input logic [3:0] k);
    return table_c[k*A_W +: A_W];
  endfunction

endpackage

// File: rtl/dsp19x2_fir_seq_delay_line.sv
// Per-lane sample history: newest sample at index 0, oldest dropped on shift.
module dsp19x2_fir_seq_delay_line
  import dsp19x2_fir_seq_pkg::*;
#(
  parameter int NUM_TAPS = 4,
  parameter int SEL_W    = $clog2(NUM_TAPS + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             shift_i,
  input  logic             flush_i,
  input  logic [B_W-1:0]   din_i,
  input  logic [SEL_W-1:0] tap_sel_i,
  output logic [B_W-1:0]   tap_o
);

  logic [NUM_TAPS-1:0][B_W-1:0] dly_q;
  logic [NUM_TAPS-1:0][B_W-1:0] dly_d;

  // History register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      dly_q <= '0;
    end else begin
      dly_q <= dly_d;
    end
  end

  // Flush wins over shift; otherwise hold.
  always_comb begin
    dly_d = dly_q;
    if (flush_i) begin
      dly_d = '0;
    end else if (shift_i) begin
      dly_d[0] = din_i;
      for (int i = 1; i < NUM_TAPS; i++) begin
        dly_d[i] = dly_q[i-1];
      end
    end else begin
      dly_d = dly_q;
    end
  end

  // Tap select; an index past the last tap reads as zero.
  always_comb begin
    tap_o = '0;
    for (int i = 0; i < NUM_TAPS; i++) begin
      if (tap_sel_i == SEL_W'(i)) begin
        tap_o = dly_q[i];
      end else begin
        tap_o = tap_o;
      end
    end
  end

endmodule

// File: rtl/dsp19x2_fir_sequencer.sv
// Sequences one DSP19X2 as a dual-lane FIR: accept a sample pair, issue the taps, capture Z.
// Optional FLUSH input enabled by defining DSP19X2_FIR_SEQ_FLUSH_EN.
module dsp19x2_fir_sequencer
  import dsp19x2_fir_seq_pkg::*;
#(
  parameter int                      NUM_TAPS       = 4,
  parameter int                      DSP_LATENCY    = 3,
  parameter logic [NUM_TAPS*A_W-1:0] COEFF1         = '0,
  parameter logic [NUM_TAPS*A_W-1:0] COEFF2         = '0,
  parameter bit                      COEFF_UNSIGNED = 1'b0,
  parameter bit                      DATA_UNSIGNED  = 1'b0,
  parameter logic [SHIFT_W-1:0]      RESULT_SHIFT   = 5'd0,
  parameter bit                      ROUND_EN       = 1'b0,
  parameter bit                      SATURATE_EN    = 1'b0
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               S_VALID,
  output logic               S_READY,
  input  logic [B_W-1:0]     S_B1,
  input  logic [B_W-1:0]     S_B2,
`ifdef DSP19X2_FIR_SEQ_FLUSH_EN
  input  logic               FLUSH,
`endif
  output logic [A_W-1:0]     A1,
  output logic [A_W-1:0]     A2,
  output logic [B_W-1:0]     B1,
  output logic [B_W-1:0]     B2,
  output logic [2:0]         FEEDBACK,
  output logic               LOAD_ACC,
  output logic [4:0]         ACC_FIR,
  output logic               SUBTRACT,
  output logic               UNSIGNED_A,
  output logic               UNSIGNED_B,
  output logic [SHIFT_W-1:0] SHIFT_RIGHT,
  output logic               ROUND,
  output logic               SATURATE,
  input  logic [Z_W-1:0]     Z1,
  input  logic [Z_W-1:0]     Z2,
  output logic               M_VALID,
  input  logic               M_READY,
  output logic [Z_W-1:0]     M_Z1,
  output logic [Z_W-1:0]     M_Z2
);

  localparam int SEL_W = $clog2(NUM_TAPS + 1);

  state_e              state_q, state_d;
  logic [SEL_W-1:0]    tap_q, tap_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic [A_W-1:0]      a1_q, a1_d, a2_q, a2_d;
  logic [B_W-1:0]      b1_q, b1_d, b2_q, b2_d;
  logic [2:0]          fb_q, fb_d;
  logic                ld_q, ld_d;
  logic                mv_q, mv_d;
  logic [Z_W-1:0]      mz1_q, mz1_d, mz2_q, mz2_d;

  logic                accept_s;
  logic                flush_s;
  logic                issue_last_s;
  logic                wait_last_s;
  logic [SEL_W-1:0]    tap_idx_s;
  logic [B_W-1:0]      tap1_s, tap2_s;

`ifdef DSP19X2_FIR_SEQ_FLUSH_EN
  assign flush_s = FLUSH && (state_q == IDLE);
`else
  assign flush_s = 1'b0;
`endif

  // RESET gates ready so nothing is accepted while the block is held in reset.
  assign S_READY      = RESET && (state_q == IDLE) && (!mv_q || M_READY) && !flush_s;
  assign accept_s     = S_VALID && S_READY;
  assign issue_last_s = (state_q == ISSUE) && (tap_q == SEL_W'(NUM_TAPS - 1));
  assign wait_last_s  = (state_q == WAIT) && (wait_q == WAIT_W'(DSP_LATENCY - 1));
  assign tap_idx_s    = accept_s ? '0 : (tap_q + SEL_W'(1));

  dsp19x2_fir_seq_delay_line #(.NUM_TAPS(NUM_TAPS), .SEL_W(SEL_W)) u_dly1 (
    .clk_i(CLK), .rst_ni(RESET), .shift_i(accept_s), .flush_i(flush_s),
    .din_i(S_B1), .tap_sel_i(tap_idx_s), .tap_o(tap1_s)
  );

  dsp19x2_fir_seq_delay_line #(.NUM_TAPS(NUM_TAPS), .SEL_W(SEL_W)) u_dly2 (
    .clk_i(CLK), .rst_ni(RESET), .shift_i(accept_s), .flush_i(flush_s),
    .din_i(S_B2), .tap_sel_i(tap_idx_s), .tap_o(tap2_s)
  );

  // Sequencer state and counters.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= IDLE;
      tap_q   <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      tap_q   <= tap_d;
      wait_q  <= wait_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    tap_d   = tap_q;
    wait_d  = wait_q;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          state_d = ISSUE;
          tap_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        if (issue_last_s) begin
          state_d = WAIT;
          wait_d  = '0;
        end else begin
          tap_d = tap_q + SEL_W'(1);
        end
      end
      WAIT: begin
        if (wait_last_s) begin
          state_d = IDLE;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output next values: the tap for the coming cycle, and the result holding register.
  always_comb begin
    a1_d  = '0;
    a2_d  = '0;
    b1_d  = '0;
    b2_d  = '0;
    fb_d  = FB_CLEAR;
    ld_d  = 1'b0;
    mv_d  = mv_q;
    mz1_d = mz1_q;
    mz2_d = mz2_q;
    if (state_d == ISSUE) begin
      a1_d = coeff_slice((MAX_TAPS*A_W)'(COEFF1), 4'(tap_idx_s));
      a2_d = coeff_slice((MAX_TAPS*A_W)'(COEFF2), 4'(tap_idx_s));
      // Tap 0 is the sample being accepted this edge, before the delay line holds it.
      b1_d = accept_s ? S_B1 : tap1_s;
      b2_d = accept_s ? S_B2 : tap2_s;
      fb_d = accept_s ? FB_CLEAR : FB_ACCUM;
      ld_d = 1'b1;
    end else begin
      ld_d = 1'b0;
    end
    if (wait_last_s) begin
      mv_d  = 1'b1;
      mz1_d = Z1;
      mz2_d = Z2;
    end else if (mv_q && M_READY) begin
      mv_d = 1'b0;
    end else begin
      mv_d = mv_q;
    end
  end

  // Registered DSP controls and result port.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      a1_q  <= '0;
      a2_q  <= '0;
      b1_q  <= '0;
      b2_q  <= '0;
      fb_q  <= FB_CLEAR;
      ld_q  <= 1'b0;
      mv_q  <= 1'b0;
      mz1_q <= '0;
      mz2_q <= '0;
    end else begin
      a1_q  <= a1_d;
      a2_q  <= a2_d;
      b1_q  <= b1_d;
      b2_q  <= b2_d;
      fb_q  <= fb_d;
      ld_q  <= ld_d;
      mv_q  <= mv_d;
      mz1_q <= mz1_d;
      mz2_q <= mz2_d;
    end
  end

  assign A1          = a1_q;
  assign A2          = a2_q;
  assign B1          = b1_q;
  assign B2          = b2_q;
  assign FEEDBACK    = fb_q;
  assign LOAD_ACC    = ld_q;
  assign M_VALID     = mv_q;
  assign M_Z1        = mz1_q;
  assign M_Z2        = mz2_q;
  assign ACC_FIR     = 5'd0;
  assign SUBTRACT    = 1'b0;
  assign UNSIGNED_A  = COEFF_UNSIGNED;
  assign UNSIGNED_B  = DATA_UNSIGNED;
  assign SHIFT_RIGHT = RESULT_SHIFT;
  assign ROUND       = ROUND_EN;
  assign SATURATE    = SATURATE_EN;

endmodule

// File: tb/tb_dsp19x2_fir_sequencer.sv
// Bench for dsp19x2_fir_sequencer with a behavioural DSP19X2 MAC and a plain FIR reference.
module tb_dsp19x2_fir_sequencer;

  localparam int N = 4;
  localparam int L = 3;
  localparam logic [39:0] C1 = {10'd4, 10'd3, 10'd2, 10'd1};
  localparam logic [39:0] C2 = {4{10'h3FF}};

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        S_VALID = 1'b0;
  logic        M_READY = 1'b0;
  logic [8:0]  S_B1 = 9'd0, S_B2 = 9'd0;
  logic        S_READY, LOAD_ACC, SUBTRACT, UNSIGNED_A, UNSIGNED_B, ROUND, SATURATE, M_VALID;
  logic [9:0]  A1, A2;
  logic [8:0]  B1, B2;
  logic [2:0]  FEEDBACK;
  logic [4:0]  ACC_FIR, SHIFT_RIGHT;
  logic [18:0] Z1, Z2, M_Z1, M_Z2;
`ifdef DSP19X2_FIR_SEQ_FLUSH_EN
  logic        FLUSH = 1'b0;
`endif

  int checks = 0;
  int errors = 0;
  logic [39:0] c1v = C1;
  logic [39:0] c2v = C2;

  dsp19x2_fir_sequencer #(
    .NUM_TAPS(N), .DSP_LATENCY(L), .COEFF1(C1), .COEFF2(C2),
    .COEFF_UNSIGNED(1'b0), .DATA_UNSIGNED(1'b0), .RESULT_SHIFT(5'd0),
    .ROUND_EN(1'b0), .SATURATE_EN(1'b0)
  ) dut (
    .CLK(CLK), .RESET(RESET), .S_VALID(S_VALID), .S_READY(S_READY),
    .S_B1(S_B1), .S_B2(S_B2),
`ifdef DSP19X2_FIR_SEQ_FLUSH_EN
    .FLUSH(FLUSH),
`endif
    .A1(A1), .A2(A2), .B1(B1), .B2(B2), .FEEDBACK(FEEDBACK), .LOAD_ACC(LOAD_ACC),
    .ACC_FIR(ACC_FIR), .SUBTRACT(SUBTRACT), .UNSIGNED_A(UNSIGNED_A), .UNSIGNED_B(UNSIGNED_B),
    .SHIFT_RIGHT(SHIFT_RIGHT), .ROUND(ROUND), .SATURATE(SATURATE),
    .Z1(Z1), .Z2(Z2), .M_VALID(M_VALID), .M_READY(M_READY), .M_Z1(M_Z1), .M_Z2(M_Z2)
  );

  always #5 CLK = ~CLK;

  // DSP19X2 stand-in: input register, accumulator, output register (three cycles after the last tap).
  logic signed [9:0]  ra1 = '0, ra2 = '0;
  logic signed [8:0]  rb1 = '0, rb2 = '0;
  logic [2:0]         rfb = 3'b001;
  logic               rld = 1'b0;
  logic [18:0]        acc1 = '0, acc2 = '0, z1r = '0, z2r = '0;
  wire  signed [18:0] p1 = ra1 * rb1;
  wire  signed [18:0] p2 = ra2 * rb2;
  assign Z1 = z1r;
  assign Z2 = z2r;

  always @(posedge CLK) begin
    ra1 <= A1;  ra2 <= A2;  rb1 <= B1;  rb2 <= B2;
    rfb <= FEEDBACK;  rld <= LOAD_ACC;
    if (rld) begin
      acc1 <= ((rfb == 3'b001) ? 19'd0 : acc1) + p1;
      acc2 <= ((rfb == 3'b001) ? 19'd0 : acc2) + p2;
    end
    z1r <= acc1;
    z2r <= acc2;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [18:0] fir_ref(input logic [8:0] h [N], input logic [39:0] c);
    int sum = 0;
    for (int k = 0; k < N; k++) begin
      sum += int'($signed(c[k*10 +: 10])) * int'($signed(h[k]));
    end
    return 19'(sum);
  endfunction

  // Reference model, one update per cycle, checking every DSP-side and result-side output.
  logic [8:0]  h1 [N];
  logic [8:0]  h2 [N];
  bit          active = 1'b0;
  bit          exp_mv = 1'b0;
  int          ph = 0;
  logic [18:0] pend1, pend2, exp_z1, exp_z2;

  initial begin
    for (int i = 0; i < N; i++) begin h1[i] = 9'd0; h2[i] = 9'd0; end
  end

  always @(negedge CLK) begin : mon
    bit rdy;
    int k;
    if (!RESET) begin
      chk("rst_sready", 32'(S_READY), 32'd0);
      chk("rst_a", 32'({A1, A2}), 32'd0);
      chk("rst_b", 32'({B1, B2}), 32'd0);
      chk("rst_fb", 32'(FEEDBACK), 32'd1);
      chk("rst_ld", 32'(LOAD_ACC), 32'd0);
      chk("rst_mvalid", 32'(M_VALID), 32'd0);
      chk("rst_mz1", 32'(M_Z1), 32'd0);
      chk("rst_mz2", 32'(M_Z2), 32'd0);
      active = 1'b0; exp_mv = 1'b0; ph = 0;
      for (int i = 0; i < N; i++) begin h1[i] = 9'd0; h2[i] = 9'd0; end
    end else begin
      if (active) begin
        ph++;
        if (ph == N + L + 1) begin
          active = 1'b0; exp_mv = 1'b1; exp_z1 = pend1; exp_z2 = pend2;
        end
      end
      if (active && ph >= 1 && ph <= N) begin
        k = ph - 1;
        chk("tap_a1", 32'(A1), 32'(c1v[k*10 +: 10]));
        chk("tap_a2", 32'(A2), 32'(c2v[k*10 +: 10]));
        chk("tap_b1", 32'(B1), 32'(h1[k]));
        chk("tap_b2", 32'(B2), 32'(h2[k]));
        chk("tap_ld", 32'(LOAD_ACC), 32'd1);
        chk("tap_fb", 32'(FEEDBACK), (k == 0) ? 32'd1 : 32'd0);
      end else begin
        chk("idle_ab", 32'({A1, A2, B1, B2}), 32'd0);
        chk("idle_ld", 32'(LOAD_ACC), 32'd0);
        chk("idle_fb", 32'(FEEDBACK), 32'd1);
      end
      chk("m_valid", 32'(M_VALID), 32'(exp_mv));
      if (exp_mv) begin
        chk("m_z1", 32'(M_Z1), 32'(exp_z1));
        chk("m_z2", 32'(M_Z2), 32'(exp_z2));
      end
      rdy = !active && (!exp_mv || M_READY);
`ifdef DSP19X2_FIR_SEQ_FLUSH_EN
      if (FLUSH && !active) begin
        rdy = 1'b0;
        for (int i = 0; i < N; i++) begin h1[i] = 9'd0; h2[i] = 9'd0; end
      end
`endif
      chk("s_ready", 32'(S_READY), 32'(rdy));
      if (exp_mv && M_READY) exp_mv = 1'b0;
      if (S_VALID && rdy) begin
        for (int i = N - 1; i > 0; i--) begin h1[i] = h1[i-1]; h2[i] = h2[i-1]; end
        h1[0] = S_B1; h2[0] = S_B2;
        pend1 = fir_ref(h1, c1v);
        pend2 = fir_ref(h2, c2v);
        active = 1'b1; ph = 0;
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic send(input logic [8:0] b1, input logic [8:0] b2, input bit rnd_mr);
    bit ok = 1'b0;
    S_VALID = 1'b1; S_B1 = b1; S_B2 = b2;
    for (int i = 0; i < 300; i++) begin
      if (rnd_mr) begin M_READY = 1'($urandom_range(0, 1)); #1; end
      if (S_READY) begin ok = 1'b1; step(); break; end
      step();
    end
    S_VALID = 1'b0;
    chk("send_timeout", 32'(ok), 32'd1);
  endtask

  task automatic get_result(output logic [18:0] z1, output logic [18:0] z2, output int lat);
    bit ok = 1'b0;
    lat = 0; z1 = '0; z2 = '0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge CLK);
      if (M_VALID) begin z1 = M_Z1; z2 = M_Z2; lat = c; ok = 1'b1; break; end
    end
    chk("result_timeout", 32'(ok), 32'd1);
    @(posedge CLK);
    #1;
  endtask

  initial begin : stim
    logic [18:0] z1, z2;
    int lat;
    int t1_exp [5] = '{1, 2, 3, 4, 0};
    logic [8:0] imp;

    M_READY = 1'b1;
    repeat (3) step();
    chk("reset_sready", 32'(S_READY), 32'd0);
    chk("reset_fb", 32'(FEEDBACK), 32'd1);
    RESET = 1'b1;
    step();

    // Impulse through lane 1.
    for (int i = 0; i < 5; i++) begin
      imp = (i == 0) ? 9'd1 : 9'd0;
      send(imp, 9'd0, 1'b0);
      get_result(z1, z2, lat);
      chk("t1_latency", 32'(lat), 32'd8);
      chk("t1_z1", 32'(z1), 32'(t1_exp[i]));
      chk("t1_z2", 32'(z2), 32'd0);
    end

    // Signed: (-1) x (-1) on lane 2.
    send(9'd0, 9'h1FF, 1'b0);
    get_result(z1, z2, lat);
    chk("t2_z2", 32'(z2), 32'h00001);
    chk("t2_z1", 32'(z1), 32'd0);

    // Result held off by M_READY.
    M_READY = 1'b0;
    send(9'd0, 9'd0, 1'b0);
    get_result(z1, z2, lat);
    for (int i = 0; i < 20; i++) begin
      chk("t3_sready_low", 32'(S_READY), 32'd0);
      chk("t3_mvalid_hold", 32'(M_VALID), 32'd1);
      chk("t3_mz1_hold", 32'(M_Z1), 32'd0);
      chk("t3_mz2_hold", 32'(M_Z2), 32'd1);
      step();
    end
    S_VALID = 1'b1; S_B1 = 9'd1; S_B2 = 9'd0; M_READY = 1'b1;
    #1;
    chk("t3_same_cycle_ready", 32'(S_READY), 32'd1);
    step();
    S_VALID = 1'b0;
    chk("t3_mvalid_clr", 32'(M_VALID), 32'd0);
    chk("t3_tap0_ld", 32'(LOAD_ACC), 32'd1);

    // Reset during the tap-2 cycle.
    step();
    step();
    chk("t4_tap2_a1", 32'(A1), 32'd3);
    RESET = 1'b0;
    #1;
    chk("t4_rst_ab", 32'({A1, A2, B1, B2}), 32'd0);
    chk("t4_rst_fb", 32'(FEEDBACK), 32'd1);
    chk("t4_rst_ld", 32'(LOAD_ACC), 32'd0);
    chk("t4_rst_sready", 32'(S_READY), 32'd0);
    step();
    step();
    RESET = 1'b1;
    for (int i = 0; i < 15; i++) begin
      chk("t4_no_mvalid", 32'(M_VALID), 32'd0);
      step();
    end
    for (int i = 0; i < 5; i++) begin
      imp = (i == 0) ? 9'd1 : 9'd0;
      send(imp, 9'd0, 1'b0);
      get_result(z1, z2, lat);
      chk("t4_z1", 32'(z1), 32'(t1_exp[i]));
    end

    // FEEDBACK / LOAD_ACC pattern for one accept.
    send(9'd7, 9'd3, 1'b0);
    for (int i = 0; i < 7; i++) begin
      chk("t5_ld", 32'(LOAD_ACC), (i < N) ? 32'd1 : 32'd0);
      chk("t5_fb", 32'(FEEDBACK), (i == 0 || i >= N) ? 32'd1 : 32'd0);
      step();
    end
    get_result(z1, z2, lat);
    chk("t5_z1", 32'(z1), 32'd7);

`ifdef DSP19X2_FIR_SEQ_FLUSH_EN
    for (int i = 0; i < N; i++) begin
      send(9'd5, 9'd5, 1'b0);
      get_result(z1, z2, lat);
    end
    FLUSH = 1'b1;
    #1;
    chk("t6_flush_sready", 32'(S_READY), 32'd0);
    step();
    FLUSH = 1'b0;
    send(9'd1, 9'd0, 1'b0);
    get_result(z1, z2, lat);
    chk("t6_z1", 32'(z1), 32'd1);
    chk("t6_z2", 32'(z2), 32'd0);
`endif

    // Random samples and back-pressure, checked by the reference model.
    for (int n = 0; n < 40; n++) begin
      send(9'($urandom_range(0, 511)), 9'($urandom_range(0, 511)), 1'b1);
      repeat ($urandom_range(0, 3)) begin
        M_READY = 1'($urandom_range(0, 1));
        step();
      end
    end
    M_READY = 1'b1;
    repeat (20) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dsp19x2_fir_sequencer.md
Name: dsp19x2_fir_sequencer

Overview:
Upstream control stage for one DSP19X2 in MULTIPLY_ACCUMULATE mode, used as a dual-lane NUM_TAPS FIR.
- Accepts one sample pair per valid/ready handshake and shifts it into per-lane delay lines.
- Issues NUM_TAPS multiply-accumulate cycles, driving coefficients on A and delayed samples on B.
- Captures Z1/Z2 after the fixed DSP latency and presents them on a valid/ready result port.

Parameters:
NUM_TAPS, 4, taps per lane, legal 2..8
DSP_LATENCY, 3, cycles from last tap cycle to Z valid (DSP19X2 with INPUT_REG_EN=TRUE and OUTPUT_REG_EN=TRUE), legal 1..7
COEFF1, 0, packed NUM_TAPS*10 bits, lane-1 coefficients, tap k in bits [10k+9:10k]
COEFF2, 0, packed NUM_TAPS*10 bits, lane-2 coefficients, same layout
COEFF_UNSIGNED, 0, constant driven on UNSIGNED_A
DATA_UNSIGNED, 0, constant driven on UNSIGNED_B
RESULT_SHIFT, 0, 5-bit constant driven on SHIFT_RIGHT
ROUND_EN, 0, constant driven on ROUND
SATURATE_EN, 0, constant driven on SATURATE

Ports:
CLK  in  1  clock; all logic on the rising edge
RESET  in  1  asynchronous, active-low reset
S_VALID  in  1  sample pair valid
S_READY  out  1  sample pair accepted when S_VALID and S_READY are both high
S_B1  in  9  lane-1 sample
S_B2  in  9  lane-2 sample
A1, A2  out  10 each  coefficient to DSP
B1, B2  out  9 each  delayed sample to DSP
FEEDBACK  out  3  DSP feedback select
LOAD_ACC  out  1  DSP accumulator load
ACC_FIR  out  5  tied to 0
SUBTRACT  out  1  tied to 0
UNSIGNED_A, UNSIGNED_B, SHIFT_RIGHT, ROUND, SATURATE  out  1/1/5/1/1  driven from parameters
Z1, Z2  in  19 each  DSP results
M_VALID  out  1  result valid
M_READY  in  1  result consumed when M_VALID and M_READY are both high
M_Z1, M_Z2  out  19 each  held results

Behaviour:
- Reset (RESET=0): delay lines, state, counters and output holding register go to 0.
  - Outputs under reset: S_READY=0, M_VALID=0, A/B=0, FEEDBACK=3'b001, LOAD_ACC=0, M_Z*=0.
  - Reset mid-operation discards any in-flight result; no late M_VALID may follow.
- FSM states:
  - IDLE -> ISSUE on accept.
  - ISSUE runs NUM_TAPS cycles, then -> WAIT.
  - WAIT runs DSP_LATENCY cycles, then captures Z and -> IDLE.
- S_READY = (state==IDLE) && (!M_VALID || M_READY).
- Accept at edge T: delay line shifts, newest at index 0. Oldest sample is dropped.
- Tap k (0..NUM_TAPS-1) is presented during cycle T+1+k, all outputs registered:
  - A1 = COEFF1[k], A2 = COEFF2[k].
  - B1/B2 = delay[k].
  - LOAD_ACC = 1.
  - FEEDBACK = 3'b001 for k=0 (clears, loads product) and 3'b000 otherwise (accumulates).
- Outside ISSUE: LOAD_ACC = 0 (DSP accumulator holds), A = B = 0, FEEDBACK = 3'b001.
- Z capture: sampled at the end of cycle T+NUM_TAPS+DSP_LATENCY into M_Z1/M_Z2.
  - M_VALID rises at T+NUM_TAPS+DSP_LATENCY+1.
  - M_VALID and M_Z* stay stable until the M_READY handshake.
- Simultaneous M_READY handshake and accept in the same cycle is legal: M_VALID clears while the new computation starts.
- Back-to-back throughput: one result per NUM_TAPS+DSP_LATENCY+1 cycles when M_READY is held high.
- No arithmetic is performed in this block; width and sign interpretation belong to the DSP.

Optional Feature:
DSP19X2_FIR_SEQ_FLUSH_EN
- Defined: adds input FLUSH (1 bit).
  - FLUSH high during IDLE zeros both delay lines at that edge.
  - S_READY is forced low during that cycle.
  - FLUSH outside IDLE is ignored.
- Undefined: no FLUSH port; delay lines clear only on reset.

Decomposition:
- Package dsp19x2_fir_seq_pkg holds:
  - state enum {IDLE, ISSUE, WAIT};
  - width constants (A_W=10, B_W=9, Z_W=19);
  - FEEDBACK constants FB_ACCUM=3'b000 and FB_CLEAR=3'b001.
- Sub-module dsp19x2_fir_seq_delay_line: parameterized NUM_TAPS x 9-bit shift register with shift, flush and tap-select ports. One instance per lane.

Test Plan:
1. NUM_TAPS=4, COEFF1={4,3,2,1} (tap0=1), impulse S_B1=1 then four zeros -> M_Z1 = 1,2,3,4,0.
   - First M_VALID exactly 8 cycles after the first accept.
2. Signed mode, COEFF2 all 10'h3FF, S_B2=9'h1FF once -> M_Z2=19'h00001.
   - Lane 1 is unaffected (0 with zero input).
3. M_READY held 0 for 20 cycles after a result:
   - S_READY stays 0 and M_Z* stay stable.
   - Raising M_READY together with S_VALID accepts in that same cycle.
4. Assert RESET during the ISSUE cycle for tap 2:
   - all outputs return to reset values;
   - no M_VALID follows;
   - the next impulse reproduces scenario 1.
5. Check FEEDBACK/LOAD_ACC sequence per accept:
   - exactly one 001 plus LOAD_ACC=1 cycle, then three 000 plus LOAD_ACC=1 cycles;
   - LOAD_ACC=0 at all other times.
6. With DSP19X2_FIR_SEQ_FLUSH_EN: fill with 5s, FLUSH in IDLE, impulse 1 -> M_Z1=1, showing no residue from the 5s.
